// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI3 master port between the I-cache (m0, reads only)
// and the D-cache (m1, reads and writes), holding m1 reads behind its own outstanding writes.
module axi_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic [3:0]  m1_awlen,
  input  logic [2:0]  m1_awsize,
  input  logic [1:0]  m1_awburst,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wlast,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {R_IDLE = 3'b001, R_GNT0 = 3'b010, R_GNT1 = 3'b100} r_state_t;
  r_state_t   r_state, w_next;
  logic       r_ar_done, r_last_grant;
  logic [1:0] r_wr_pend;
  logic       w_gnt0, w_gnt1, w_m1_ok, w_pick1, w_r_end, w_aw_open, w_aw_hs, w_b_hs, w_unused;
  assign w_gnt0 = r_state == R_GNT0;
  assign w_gnt1 = r_state == R_GNT1;
  assign w_m1_ok = m1_arvalid && r_wr_pend == 2'd0;
  // m1 wins when alone, under fixed priority, or when m0 was served last
  assign w_pick1 = w_m1_ok && (!m0_arvalid || !RR_EN || !r_last_grant);
  assign w_r_end = rvalid && rready && rlast;
  assign w_aw_open = aresetn && r_wr_pend != 2'd3;
  assign w_aw_hs = awvalid && awready;
  assign w_b_hs = bvalid && bready && r_wr_pend != 2'd0;
  assign w_unused = ^{rid, bid};
  always_comb begin
    w_next = r_state == R_IDLE ? ((m0_arvalid || w_m1_ok) ? (w_pick1 ? R_GNT1 : R_GNT0) : R_IDLE)
                               : (w_r_end ? R_IDLE : r_state);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= R_IDLE;
      r_ar_done    <= 1'b0;
      r_last_grant <= 1'b0;
      r_wr_pend    <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_ar_done <= w_next == R_IDLE ? 1'b0 : (r_ar_done || (arvalid && arready));
      if (r_state == R_IDLE && w_next != R_IDLE) r_last_grant <= w_pick1;
      r_wr_pend <= r_wr_pend + {1'b0, w_aw_hs} - {1'b0, w_b_hs};
    end
  end
  assign arid    = {3'b000, w_gnt1};
  assign araddr  = w_gnt1 ? m1_araddr : m0_araddr;
  assign arlen   = w_gnt1 ? m1_arlen : m0_arlen;
  assign arsize  = w_gnt1 ? m1_arsize : m0_arsize;
  assign arburst = w_gnt1 ? m1_arburst : m0_arburst;
  assign arvalid = !r_ar_done && ((w_gnt0 && m0_arvalid) || (w_gnt1 && m1_arvalid));
  assign m0_arready = w_gnt0 && arready && !r_ar_done;
  assign m1_arready = w_gnt1 && arready && !r_ar_done;
  assign m0_rdata  = rdata;
  assign m0_rresp  = rresp;
  assign m0_rlast  = rlast;
  assign m0_rvalid = w_gnt0 && rvalid;
  assign m1_rdata  = rdata;
  assign m1_rresp  = rresp;
  assign m1_rlast  = rlast;
  assign m1_rvalid = w_gnt1 && rvalid;
  assign rready = (w_gnt0 && m0_rready) || (w_gnt1 && m1_rready);
  assign awid       = 4'b0001;
  assign awaddr     = m1_awaddr;
  assign awlen      = m1_awlen;
  assign awsize     = m1_awsize;
  assign awburst    = m1_awburst;
  assign awvalid    = m1_awvalid && w_aw_open;
  assign m1_awready = awready && w_aw_open;
  assign wid       = 4'b0001;
  assign wdata     = m1_wdata;
  assign wstrb     = m1_wstrb;
  assign wlast     = m1_wlast;
  assign wvalid    = m1_wvalid;
  assign m1_wready = wready;
  assign m1_bresp  = bresp;
  assign m1_bvalid = bvalid;
  assign bready    = m1_bready;
endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: random and directed checks of both arbitration modes against a grant/write-count model.
module tb_axi_arbiter;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, rdata;
  logic [3:0] m0_arlen, m1_arlen, m1_awlen, m1_wstrb, rid, bid;
  logic [2:0] m0_arsize, m1_arsize, m1_awsize;
  logic [1:0] m0_arburst, m1_arburst, m1_awburst, rresp, bresp;
  logic m0_arvalid, m1_arvalid, m0_rready, m1_rready, m1_awvalid, m1_wlast, m1_wvalid, m1_bready;
  logic arready, rlast, rvalid, awready, wready, bvalid;
  logic o_m0_arready [2], o_m1_arready [2], o_m0_rlast [2], o_m1_rlast [2], o_m0_rvalid [2], o_m1_rvalid [2];
  logic [31:0] o_m0_rdata [2], o_m1_rdata [2], o_araddr [2], o_awaddr [2], o_wdata [2];
  logic [1:0] o_m0_rresp [2], o_m1_rresp [2], o_m1_bresp [2], o_arburst [2], o_awburst [2];
  logic o_m1_awready [2], o_m1_wready [2], o_m1_bvalid [2], o_arvalid [2], o_rready [2];
  logic o_awvalid [2], o_wlast [2], o_wvalid [2], o_bready [2];
  logic [3:0] o_arid [2], o_arlen [2], o_awid [2], o_awlen [2], o_wid [2], o_wstrb [2];
  logic [2:0] o_arsize [2], o_awsize [2];
  int n_pass = 0, n_total = 0;

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_arbiter #(.RR_EN(g == 0)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_arvalid(m0_arvalid), .m0_arready(o_m0_arready[g]), .m0_rdata(o_m0_rdata[g]),
      .m0_rresp(o_m0_rresp[g]), .m0_rlast(o_m0_rlast[g]), .m0_rvalid(o_m0_rvalid[g]), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_arvalid(m1_arvalid), .m1_arready(o_m1_arready[g]), .m1_rdata(o_m1_rdata[g]),
      .m1_rresp(o_m1_rresp[g]), .m1_rlast(o_m1_rlast[g]), .m1_rvalid(o_m1_rvalid[g]), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
      .m1_awvalid(m1_awvalid), .m1_awready(o_m1_awready[g]), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(o_m1_wready[g]),
      .m1_bresp(o_m1_bresp[g]), .m1_bvalid(o_m1_bvalid[g]), .m1_bready(m1_bready),
      .arid(o_arid[g]), .araddr(o_araddr[g]), .arlen(o_arlen[g]), .arsize(o_arsize[g]),
      .arburst(o_arburst[g]), .arvalid(o_arvalid[g]), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(o_rready[g]),
      .awid(o_awid[g]), .awaddr(o_awaddr[g]), .awlen(o_awlen[g]), .awsize(o_awsize[g]),
      .awburst(o_awburst[g]), .awvalid(o_awvalid[g]), .awready(awready),
      .wid(o_wid[g]), .wdata(o_wdata[g]), .wstrb(o_wstrb[g]), .wlast(o_wlast[g]), .wvalid(o_wvalid[g]),
      .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(o_bready[g])
    );
  end

  task automatic clear_inputs();
    {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arvalid, m0_rready} = '0;
    {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arvalid, m1_rready} = '0;
    {m1_awaddr, m1_awlen, m1_awsize, m1_awburst, m1_awvalid} = '0;
    {m1_wdata, m1_wstrb, m1_wlast, m1_wvalid, m1_bready} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Plays the interconnect for one read burst on instance inst; reports who got it and any routing faults.
  task automatic serve(input int inst, input int beats, output int gnt, output int lat, output int bad);
    lat = 0; bad = 0; gnt = -1;
    while (o_arvalid[inst] !== 1'b1 && lat < 20) begin
      @(negedge aclk);
      lat++;
    end
    if (o_arvalid[inst] !== 1'b1) return;
    gnt = o_arid[inst][0] ? 1 : 0;
    if (o_arid[inst][3:1] !== 3'b000) bad++;
    if (o_araddr[inst] !== (gnt == 1 ? m1_araddr : m0_araddr)) bad++;
    arready = 1'b1;
    #1;
    if ((gnt == 1 ? o_m1_arready[inst] : o_m0_arready[inst]) !== 1'b1) bad++;
    @(negedge aclk);
    arready = 1'b0;
    if (o_arvalid[inst] !== 1'b0) bad++;
    if (gnt == 1) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      rvalid = 1'b1;
      rlast = (b == beats - 1);
      rdata = $urandom;
      #1;
      if ((gnt == 1 ? o_m1_rvalid[inst] : o_m0_rvalid[inst]) !== 1'b1) bad++;
      if ((gnt == 1 ? o_m0_rvalid[inst] : o_m1_rvalid[inst]) !== 1'b0) bad++;
      if ((gnt == 1 ? o_m1_rdata[inst] : o_m0_rdata[inst]) !== rdata) bad++;
      if (o_rready[inst] !== 1'b1) bad++;
      @(negedge aclk);
    end
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    aresetn = 1'b0;
    {m0_arvalid, m1_arvalid, m1_awvalid, awready, rvalid, rlast, arready, m0_rready, m1_rready} = '1;
    repeat (2) @(negedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_total++; if (o_arvalid[i] !== 1'b0) $display("FAIL rst_arvalid[%0d]: got %b want 0", i, o_arvalid[i]); else n_pass++;
      n_total++; if (o_awvalid[i] !== 1'b0) $display("FAIL rst_awvalid[%0d]: got %b want 0", i, o_awvalid[i]); else n_pass++;
      n_total++; if (o_m1_awready[i] !== 1'b0) $display("FAIL rst_m1_awready[%0d]: got %b want 0", i, o_m1_awready[i]); else n_pass++;
      n_total++; if ({o_m0_arready[i], o_m1_arready[i]} !== 2'b00) $display("FAIL rst_arready[%0d]: got %b%b want 00", i, o_m0_arready[i], o_m1_arready[i]); else n_pass++;
      n_total++; if ({o_m0_rvalid[i], o_m1_rvalid[i]} !== 2'b00) $display("FAIL rst_rvalid[%0d]: got %b%b want 00", i, o_m0_rvalid[i], o_m1_rvalid[i]); else n_pass++;
    end
    {arready, rvalid, rlast, m1_awvalid} = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 2; i++) begin
      n_total++; if ({o_arvalid[i], o_arid[i]} !== 5'b10001) $display("FAIL first_tie[%0d]: got arvalid=%b arid=%h want 1/1", i, o_arvalid[i], o_arid[i]); else n_pass++;
    end
  endtask

  task automatic test_single_m0();
    int gnt, lat, bad;
    do_reset();
    m0_araddr = 32'h1FC00000;
    m0_arlen = 4'd3;
    m0_arvalid = 1'b1;
    #1;
    n_total++; if (o_arvalid[0] !== 1'b0) $display("FAIL m0_same_cycle: got arvalid=%b want 0", o_arvalid[0]); else n_pass++;
    serve(0, 4, gnt, lat, bad);
    n_total++; if (gnt !== 0) $display("FAIL m0_grant: got %0d want 0", gnt); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL m0_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL m0_burst_routing: got %0d faults want 0", bad); else n_pass++;
    rvalid = 1'b1;
    #1;
    n_total++; if ({o_m0_rvalid[0], o_m1_rvalid[0], o_rready[0], o_arvalid[0]} !== 4'b0000) $display("FAIL m0_back_idle: got %b%b%b%b want 0000", o_m0_rvalid[0], o_m1_rvalid[0], o_rready[0], o_arvalid[0]); else n_pass++;
    rvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    int gnt, lat, bad, exp, last;
    bit req0, req1;
    do_reset();
    last = 0; req0 = 1'b1; req1 = 1'b1;
    for (int r = 0; r < 10; r++) begin
      m0_araddr = $urandom;
      m1_araddr = $urandom;
      m0_arvalid = req0;
      m1_arvalid = req1;
      exp = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
      serve(0, $urandom_range(1, 4), gnt, lat, bad);
      n_total++; if (gnt !== exp) $display("FAIL rr_grant r%0d: got %0d want %0d", r, gnt, exp); else n_pass++;
      n_total++; if (lat !== 1) $display("FAIL rr_latency r%0d: got %0d want 1", r, lat); else n_pass++;
      n_total++; if (bad !== 0) $display("FAIL rr_routing r%0d: got %0d faults want 0", r, bad); else n_pass++;
      last = exp;
      if (exp == 1) req1 = 1'b0; else req0 = 1'b0;
      req0 |= 1'($urandom_range(0, 1));
      req1 |= 1'($urandom_range(0, 1));
      if (!req0 && !req1) req1 = 1'b1;
    end
  endtask

  task automatic test_fixed_priority();
    int gnt, lat, bad;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      m0_arvalid = 1'b1;
      m1_arvalid = 1'b1;
      serve(1, 2, gnt, lat, bad);
      n_total++; if (gnt !== 1) $display("FAIL fixed_grant r%0d: got %0d want 1", r, gnt); else n_pass++;
      n_total++; if (lat !== 1 || bad !== 0) $display("FAIL fixed_burst r%0d: got lat=%0d faults=%0d want 1/0", r, lat, bad); else n_pass++;
    end
  endtask

  task automatic test_read_after_write();
    int gnt, lat, bad;
    do_reset();
    m1_awaddr = 32'h80000010; m1_awsize = 3'd2; m1_awburst = 2'd1; m1_awvalid = 1'b1;
    m1_wdata = 32'hDEADBEEF; m1_wstrb = 4'hF; m1_wlast = 1'b1; m1_wvalid = 1'b1;
    awready = 1'b1; wready = 1'b1;
    #1;
    n_total++; if ({o_awvalid[0], o_m1_awready[0], o_awaddr[0]} !== {2'b11, 32'h80000010}) $display("FAIL aw_pass: got %b%b %h want 11 80000010", o_awvalid[0], o_m1_awready[0], o_awaddr[0]); else n_pass++;
    n_total++; if ({o_wvalid[0], o_m1_wready[0], o_wdata[0]} !== {2'b11, 32'hDEADBEEF}) $display("FAIL w_pass: got %b%b %h want 11 deadbeef", o_wvalid[0], o_m1_wready[0], o_wdata[0]); else n_pass++;
    n_total++; if ({o_awid[0], o_wid[0]} !== 8'h11) $display("FAIL aw_w_ids: got %h%h want 11", o_awid[0], o_wid[0]); else n_pass++;
    @(negedge aclk);
    {m1_awvalid, m1_wvalid, awready, wready} = '0;
    m1_arvalid = 1'b1;
    m1_araddr = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      n_total++; if (o_arvalid[0] !== 1'b0) $display("FAIL raw_blocked c%0d: got arvalid=%b want 0", k, o_arvalid[0]); else n_pass++;
    end
    bvalid = 1'b1; bresp = 2'b10; m1_bready = 1'b1;
    #1;
    n_total++; if ({o_m1_bvalid[0], o_bready[0], o_m1_bresp[0]} !== 4'b1110) $display("FAIL b_pass: got %b%b%b want 1110", o_m1_bvalid[0], o_bready[0], o_m1_bresp[0]); else n_pass++;
    @(negedge aclk);
    {bvalid, m1_bready, bresp} = '0;
    serve(0, 2, gnt, lat, bad);
    n_total++; if (gnt !== 1 || lat !== 1) $display("FAIL raw_release: got gnt=%0d lat=%0d want 1/1", gnt, lat); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL raw_routing: got %0d faults want 0", bad); else n_pass++;
  endtask

  task automatic test_write_pending();
    int pend;
    bit inc, dec;
    do_reset();
    pend = 0;
    for (int c = 0; c < 60; c++) begin
      m1_awvalid = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 3) != 0);
      bvalid = pend > 0 ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      m1_bready = 1'($urandom_range(0, 1));
      #1;
      n_total++; if (o_awvalid[0] !== (m1_awvalid && pend != 3)) $display("FAIL pend_awvalid c%0d: got %b pend=%0d", c, o_awvalid[0], pend); else n_pass++;
      n_total++; if (o_m1_awready[0] !== (awready && pend != 3)) $display("FAIL pend_awready c%0d: got %b pend=%0d", c, o_m1_awready[0], pend); else n_pass++;
      inc = m1_awvalid && awready && pend != 3;
      dec = bvalid && m1_bready;
      pend = pend + int'(inc) - int'(dec);
      @(negedge aclk);
    end
    do_reset();
    m1_awvalid = 1'b1;
    awready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (o_awvalid[0] !== 1'b1) $display("FAIL aw_accept%0d: got %b want 1", k, o_awvalid[0]); else n_pass++;
      @(negedge aclk);
    end
    #1;
    n_total++; if ({o_awvalid[0], o_m1_awready[0]} !== 2'b00) $display("FAIL aw_full: got %b%b want 00", o_awvalid[0], o_m1_awready[0]); else n_pass++;
    bvalid = 1'b1;
    m1_bready = 1'b1;
    @(negedge aclk);
    {bvalid, m1_bready} = '0;
    #1;
    n_total++; if ({o_awvalid[0], o_m1_awready[0]} !== 2'b11) $display("FAIL aw_reopen: got %b%b want 11", o_awvalid[0], o_m1_awready[0]); else n_pass++;
    m1_awvalid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int gnt, lat, bad;
    do_reset();
    m1_araddr = $urandom;
    m1_arvalid = 1'b1;
    @(negedge aclk);
    n_total++; if ({o_arvalid[0], o_arid[0]} !== 5'b10001) $display("FAIL mid_grant: got arvalid=%b arid=%h want 1/1", o_arvalid[0], o_arid[0]); else n_pass++;
    arready = 1'b1;
    @(negedge aclk);
    {arready, m1_arvalid} = '0;
    rvalid = 1'b1;
    m1_rready = 1'b1;
    #1;
    n_total++; if (o_m1_rvalid[0] !== 1'b1) $display("FAIL mid_beat: got m1_rvalid=%b want 1", o_m1_rvalid[0]); else n_pass++;
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    m1_arvalid = 1'b1;
    #1;
    n_total++; if ({o_arvalid[0], o_m1_arready[0], o_m1_rvalid[0], o_rready[0]} !== 4'b0000) $display("FAIL mid_reset: got %b%b%b%b want 0000", o_arvalid[0], o_m1_arready[0], o_m1_rvalid[0], o_rready[0]); else n_pass++;
    repeat (2) @(negedge aclk);
    rvalid = 1'b0;
    aresetn = 1'b1;
    serve(0, 3, gnt, lat, bad);
    n_total++; if (gnt !== 1 || lat !== 1) $display("FAIL post_reset: got gnt=%0d lat=%0d want 1/1", gnt, lat); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL post_reset_routing: got %0d faults want 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_round_robin();
    test_fixed_priority();
    test_read_after_write();
    test_write_pending();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin read arbitration and 0 = fixed priority to m1.
REQ-002 SHALL have port aclk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port aresetn, in, 1; reset is asynchronous and active-low.
REQ-004 SHALL have m0 read-address group m0_araddr/arlen/arsize/arburst/arvalid, in, 32/4/3/2/1; m0 is the instruction cache.
REQ-005 SHALL have port m0_arready, out, 1.
REQ-006 SHALL have m0 read-data group m0_rdata/rresp/rlast/rvalid, out, 32/2/1/1.
REQ-007 SHALL have port m0_rready, in, 1.
REQ-008 SHALL have m1 read ports, identical in names, directions and widths to REQ-004..007 with prefix m1_; m1 is the data cache.
REQ-009 SHALL have m1 write group m1_awaddr/awlen/awsize/awburst/awvalid and m1_wdata/wstrb/wlast/wvalid, in; m1_awready and m1_wready, out.
REQ-010 SHALL have m1 response ports m1_bresp/bvalid, out, 2/1; m1_bready, in, 1.
REQ-011 SHALL have a full AXI3 master port with prefixes ar*, r*, aw*, w*, b*, driven toward the interconnect.

Function
REQ-012 SHALL implement the read FSM with one-hot states R_IDLE, R_GNT0, R_GNT1.
REQ-013 In R_IDLE, SHALL hold arvalid=0 and both m*_arready=0.
REQ-014 In R_IDLE, when at least one eligible m*_arvalid is 1, SHALL register the winner and enter R_GNT0 or R_GNT1 on the next edge (1-cycle arbitration latency).
REQ-015 On a tie with RR_EN=1, SHALL grant the master not granted most recently; last_grant resets to 0, so the first tie goes to m1.
REQ-016 On a tie with RR_EN=0, SHALL always grant m1.
REQ-017 m1 SHALL be ineligible for read grant while wr_pend != 0 (read-after-write ordering); m0 is unaffected.
REQ-018 In R_GNTx, SHALL forward mx ar* to the master port with arvalid = mx_arvalid & !ar_done, and SHALL drive mx_arready = arready & !ar_done.
REQ-019 SHALL set ar_done on the AR handshake and clear it on the return to R_IDLE.
REQ-020 SHALL drive arid = {3'b0, x}.
REQ-021 SHALL route rdata/rresp/rlast/rvalid to mx only and drive rready = mx_rready; the ungranted master sees rvalid=0.
REQ-022 SHALL return from R_GNTx to R_IDLE on rvalid & rready & rlast; a new grant is then evaluated in R_IDLE (minimum one idle cycle between bursts).
REQ-023 SHALL ignore rid for routing.
REQ-024 SHALL pass the AW and W channels combinationally from m1 to the master port, with awid = wid = 4'b0001.
REQ-025 SHALL gate awvalid and m1_awready to 0 when wr_pend = 3.
REQ-026 SHALL pass B from the master port to m1 (bvalid, bresp; bready = m1_bready).
REQ-027 wr_pend (2-bit) SHALL increment on an AW handshake and decrement on a B handshake; a simultaneous increment and decrement leaves it unchanged.
REQ-028 wr_pend SHALL never wrap.

Reset
REQ-029 While aresetn=0, SHALL force the FSM to R_IDLE and set ar_done=0, last_grant=0, wr_pend=0.
REQ-030 While aresetn=0, SHALL hold arvalid, awvalid, m*_arready, m*_rvalid and m1_awready at 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst without completing it.
REQ-032 Deasserting reset SHALL take effect on the first following edge.

Verification
REQ-033 Bench SHALL cover: m0_arvalid alone, araddr=0x1FC00000 -> arvalid asserted 1 cycle later with arid=0; after rlast handshake, FSM in R_IDLE and m1_rvalid=0 throughout.
REQ-034 Bench SHALL cover: m0 and m1 arvalid together from reset, RR_EN=1 -> m1 granted first, then m0; repeated ties alternate.
REQ-035 Bench SHALL cover: RR_EN=0 with three back-to-back ties -> m1 granted all three times.
REQ-036 Bench SHALL cover: m1 write (awaddr=0x80000010, wdata=0xDEADBEEF) followed immediately by m1 read -> read not granted until the bvalid handshake; wr_pend goes 1 then 0.
REQ-037 Bench SHALL cover: three AW handshakes with no B -> wr_pend=3 and awvalid/m1_awready held 0; one B handshake -> wr_pend=2 and AW accepted again.
REQ-038 Bench SHALL cover: aresetn pulsed low during R_GNT1 mid-burst -> arvalid=0 and FSM=R_IDLE immediately; a fresh request is served normally after release.
